aes_128_result_buffer: RTL

//  Downstream companion of the fully pipelined, unstallable aes_128 core. Tracks the

---
 rtl/aes_pkg.sv | 15 +
 rtl/aes_result_fifo.sv | 88 ++++++++
 rtl/aes_128_result_buffer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared constants for the aes_128 core and its result buffer.
//   AES_BLOCK_W     : cipher block width in bits
//   AES128_LATENCY  : cycles from the aes_128 state/key sample edge to a valid 'out'
//   cw(depth)       : width of a counter that must represent 0..depth inclusive
package aes_pkg;

    localparam int unsigned AES_BLOCK_W    = 128;
    localparam int unsigned AES128_LATENCY = 21;

    // Counter width able to hold the value 'depth' itself (full FIFO, full credit pool).
    function automatic int unsigned cw(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/aes_result_fifo.sv
// First-word-fall-through result FIFO for the aes_128 result buffer.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en      : push wr_data (accepted when not full, or when a pop happens together)
//   wr_data    : block to push
//   rd_en      : pop head (ignored while empty)
//   rd_data    : head entry, combinational; zero while empty
//   level      : occupancy 0..DEPTH
//   full/empty : occupancy flags
module aes_result_fifo
    import aes_pkg::*;
#(
    parameter int unsigned  DW    = AES_BLOCK_W,
    parameter int unsigned  DEPTH = 32,
    localparam int unsigned CW    = cw(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic [CW-1:0] level,
    output logic          full,
    output logic          empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_level;

    logic          w_do_wr;
    logic          w_do_rd;
    logic [CW-1:0] w_level_nxt;

    // Wrap by explicit compare so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty = (r_level == '0);
    assign full  = (r_level == CW'(DEPTH));

    // A write into a full FIFO is only safe when the head leaves in the same cycle.
    assign w_do_rd = rd_en & ~empty;
    assign w_do_wr = wr_en & (~full | w_do_rd);

    // Occupancy update.
    always_comb begin
        w_level_nxt = r_level;
        unique case ({w_do_wr, w_do_rd})
            2'b10:   w_level_nxt = r_level + CW'(1);
            2'b01:   w_level_nxt = r_level - CW'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_rd) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_level <= w_level_nxt;
        end
    end

    // Storage array; contents are qualified by level, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Head falls through; masked to zero when nothing is queued.
    assign rd_data = empty ? '0 : r_mem[r_rd_ptr];
    assign level   = r_level;

endmodule

// File: rtl/aes_128_result_buffer.sv
// Result buffer behind the unstallable aes_128 pipeline.
// Tracks which core pipeline slots hold real blocks, captures each ciphertext as it
// emerges LATENCY cycles after issue, and queues it for a valid/ready consumer.
// Issue is credit-gated so that every block in flight already owns a FIFO slot.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : upstream presents state/key to aes_128 this cycle
//   in_ready   : credit available; block issued when in_valid & in_ready
//   core_out   : aes_128 'out' bus
//   out_valid  : FIFO head valid
//   out_ready  : consumer accepts head
//   out_data   : FIFO head ciphertext
//   inflight   : blocks currently inside the core
//   level      : FIFO occupancy
//   err_ovf    : sticky, capture seen while FIFO full without a pop
module aes_128_result_buffer
    import aes_pkg::*;
#(
    parameter int unsigned  LATENCY = AES128_LATENCY,
    parameter int unsigned  DEPTH   = 32,
    parameter int unsigned  DW      = AES_BLOCK_W,
    localparam int unsigned CW      = cw(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] core_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [CW-1:0] inflight,
    output logic [CW-1:0] level,
    output logic          err_ovf
);

    // One extra bit so level + inflight cannot wrap.
    localparam int unsigned SW = CW + 1;

    logic [LATENCY-1:0] r_vpipe;
    logic [CW-1:0]      r_inflight;
    logic               r_in_ready;
    logic               r_err_ovf;

    logic               w_issue;
    logic               w_cap;
    logic               w_pop;
    logic               w_wr_acc;
    logic               w_full;
    logic               w_empty;
    logic [CW-1:0]      w_level;
    logic [CW-1:0]      w_inflight_nxt;
    logic [CW-1:0]      w_level_nxt;
    logic [SW-1:0]      w_used_nxt;

    assign w_issue = in_valid & r_in_ready;
    assign w_cap   = r_vpipe[LATENCY-1];
    assign w_pop   = ~w_empty & out_ready;

    // Next-cycle counters; in_ready is registered from these so a pop frees its
    // credit one cycle later and out_ready never reaches in_ready combinationally.
    always_comb begin
        w_inflight_nxt = r_inflight;
        w_level_nxt    = w_level;
        w_wr_acc       = w_cap & (~w_full | w_pop);

        unique case ({w_issue, w_cap})
            2'b10:   w_inflight_nxt = r_inflight + CW'(1);
            2'b01:   w_inflight_nxt = r_inflight - CW'(1);
            default: w_inflight_nxt = r_inflight;
        endcase

        unique case ({w_wr_acc, w_pop})
            2'b10:   w_level_nxt = w_level + CW'(1);
            2'b01:   w_level_nxt = w_level - CW'(1);
            default: w_level_nxt = w_level;
        endcase

        w_used_nxt = SW'(w_level_nxt) + SW'(w_inflight_nxt);
    end

    // Valid shadow of the core pipeline: one bit per stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vpipe <= '0;
        end else begin
            r_vpipe[0] <= w_issue;
            for (int unsigned k = 1; k < LATENCY; k++) begin
                r_vpipe[k] <= r_vpipe[k-1];
            end
        end
    end

    // Credit bookkeeping and overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
            r_in_ready <= 1'b0;
            r_err_ovf  <= 1'b0;
        end else begin
            r_inflight <= w_inflight_nxt;
            r_in_ready <= (w_used_nxt < SW'(DEPTH));
            r_err_ovf  <= r_err_ovf | (w_cap & w_full & ~w_pop);
        end
    end

    // Result queue; the capture is unconditional, the FIFO drops it only when full.
    aes_result_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_cap),
        .wr_data (core_out),
        .rd_en   (w_pop),
        .rd_data (out_data),
        .level   (w_level),
        .full    (w_full),
        .empty   (w_empty)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = ~w_empty;
    assign inflight  = r_inflight;
    assign level     = w_level;
    assign err_ovf   = r_err_ovf;

endmodule
